// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Runtime-reprogrammable raster timing generator. A pixel-clock divider gates
// a horizontal/vertical counter pair; sync, blanking and display-enable are
// decoded from the next-state counters and registered alongside them, so they
// always describe the current hpos/vpos with no skew. A new mode is written
// into a shadow copy and becomes active only at the frame wrap.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   cfg_valid    one-cycle request to load a new mode
//   cfg_h        {display, front, sync, back} horizontal fields, display in MSBs
//   cfg_v        same packing for the vertical axis
//   cfg_pol      {vs_pol, hs_pol}, sync level during the sync interval
//   cfg_pending  a mode is latched in the shadow and not yet applied
//   cfg_err      one-cycle pulse: last request rejected
//   pix_en       last system clock of the current pixel
//   hpos, vpos   current pixel column and line
//   hsync, vsync polarity-applied sync
//   hblank, vblank, de  blanking and display enable
//   line_start, frame_start  one-clock strobes at the first pixel
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int CW        = 12,
    parameter int PIX_DIV   = 1,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    input  logic [1:0]      cfg_pol,
    output logic            cfg_pending,
    output logic            cfg_err,
    output logic            pix_en,
    output logic [CW-1:0]   hpos,
    output logic [CW-1:0]   vpos,
    output logic            hsync,
    output logic            vsync,
    output logic            hblank,
    output logic            vblank,
    output logic            de,
    output logic            line_start,
    output logic            frame_start
);

    // Divider width; a PIX_DIV of 1 still gets a 1-bit register that stays 0.
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    // A mode is legal when each axis spans at most 2^CW positions.
    localparam logic [CW+1:0] SUM_LIM  = {2'b01, {CW{1'b0}}};

    localparam logic [4*CW-1:0] RST_H = {CW'(H_DISPLAY), CW'(H_FRONT),
                                         CW'(H_SYNC), CW'(H_BACK)};
    localparam logic [4*CW-1:0] RST_V = {CW'(V_DISPLAY), CW'(V_FRONT),
                                         CW'(V_SYNC), CW'(V_BACK)};
    localparam logic [1:0]      RST_POL = {VS_POL, HS_POL};

    // Decode thresholds of one axis.
    typedef struct packed {
        logic [CW-1:0] disp;
        logic [CW-1:0] ss;
        logic [CW-1:0] se;
    } axis_dec_t;

    function automatic axis_dec_t axis_decode(input logic [4*CW-1:0] t);
        axis_dec_t d;
        d.disp = t[4*CW-1:3*CW];
        d.ss   = t[4*CW-1:3*CW] + t[3*CW-1:2*CW];
        d.se   = d.ss + t[2*CW-1:CW] - C_ONE;
        return d;
    endfunction

    // Last counter value of an axis (total - 1).
    function automatic logic [CW-1:0] axis_last(input logic [4*CW-1:0] t);
        return t[4*CW-1:3*CW] + t[3*CW-1:2*CW] + t[2*CW-1:CW]
             + t[CW-1:0] - C_ONE;
    endfunction

    // Every field non-zero and the sum within 2^CW, computed two bits wider
    // so that the sum itself cannot wrap.
    function automatic logic axis_ok(input logic [4*CW-1:0] t);
        logic [CW+1:0] sum;
        sum = {2'b00, t[4*CW-1:3*CW]} + {2'b00, t[3*CW-1:2*CW]}
            + {2'b00, t[2*CW-1:CW]}   + {2'b00, t[CW-1:0]};
        return (t[4*CW-1:3*CW] != '0) && (t[3*CW-1:2*CW] != '0) &&
               (t[2*CW-1:CW] != '0)   && (t[CW-1:0] != '0)     &&
               (sum <= SUM_LIM);
    endfunction

    // State
    logic [DW-1:0]   r_div;
    logic [CW-1:0]   r_hpos;
    logic [CW-1:0]   r_vpos;
    logic [4*CW-1:0] r_act_h;
    logic [4*CW-1:0] r_act_v;
    logic [1:0]      r_act_pol;
    logic [4*CW-1:0] r_shd_h;
    logic [4*CW-1:0] r_shd_v;
    logic [1:0]      r_shd_pol;
    logic            r_pending;
    logic            r_err;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_hblank;
    logic            r_vblank;
    logic            r_de;

    // Combinational
    logic            w_pix;
    logic [CW-1:0]   w_h_last;
    logic [CW-1:0]   w_v_last;
    logic            w_h_end;
    logic            w_v_end;
    logic            w_wrap;
    logic            w_apply;
    logic [CW-1:0]   w_hpos_nxt;
    logic [CW-1:0]   w_vpos_nxt;
    axis_dec_t       w_nh;
    axis_dec_t       w_nv;
    logic [1:0]      w_npol;
    logic            w_hblank_nxt;
    logic            w_vblank_nxt;
    logic            w_hsync_nxt;
    logic            w_vsync_nxt;
    logic            w_cfg_ok;
    logic            w_accept;

    always_comb begin
        w_pix    = (r_div == DIV_LAST);
        w_h_last = axis_last(r_act_h);
        w_v_last = axis_last(r_act_v);
        w_h_end  = (r_hpos == w_h_last);
        w_v_end  = (r_vpos == w_v_last);
        w_wrap   = w_pix && w_h_end && w_v_end;
        w_apply  = w_wrap && r_pending;

        w_hpos_nxt = r_hpos;
        w_vpos_nxt = r_vpos;
        if (w_pix) begin
            if (w_h_end) begin
                w_hpos_nxt = '0;
                w_vpos_nxt = w_v_end ? '0 : (r_vpos + C_ONE);
            end else begin
                w_hpos_nxt = r_hpos + C_ONE;
            end
        end

        // The decode describes the position the counters move to, so on the
        // apply edge it must already use the shadow timing.
        w_nh   = axis_decode(w_apply ? r_shd_h : r_act_h);
        w_nv   = axis_decode(w_apply ? r_shd_v : r_act_v);
        w_npol = w_apply ? r_shd_pol : r_act_pol;

        w_hblank_nxt = (w_hpos_nxt >= w_nh.disp);
        w_vblank_nxt = (w_vpos_nxt >= w_nv.disp);
        w_hsync_nxt  = ((w_hpos_nxt >= w_nh.ss) && (w_hpos_nxt <= w_nh.se))
                     ? w_npol[0] : ~w_npol[0];
        w_vsync_nxt  = ((w_vpos_nxt >= w_nv.ss) && (w_vpos_nxt <= w_nv.se))
                     ? w_npol[1] : ~w_npol[1];

        w_cfg_ok = axis_ok(cfg_h) && axis_ok(cfg_v);
        w_accept = cfg_valid && w_cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_hpos    <= '0;
            r_vpos    <= '0;
            r_act_h   <= RST_H;
            r_act_v   <= RST_V;
            r_act_pol <= RST_POL;
            r_shd_h   <= RST_H;
            r_shd_v   <= RST_V;
            r_shd_pol <= RST_POL;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
            r_hsync   <= ~HS_POL;
            r_vsync   <= ~VS_POL;
            r_hblank  <= 1'b0;
            r_vblank  <= 1'b0;
            r_de      <= 1'b1;
        end else begin
            r_div  <= w_pix ? '0 : (r_div + DIV_ONE);
            r_hpos <= w_hpos_nxt;
            r_vpos <= w_vpos_nxt;

            if (w_apply) begin
                r_act_h   <= r_shd_h;
                r_act_v   <= r_shd_v;
                r_act_pol <= r_shd_pol;
            end

            // A request on the apply edge overwrites the shadow after the old
            // shadow has been copied out, so it waits for the next frame.
            if (w_accept) begin
                r_shd_h   <= cfg_h;
                r_shd_v   <= cfg_v;
                r_shd_pol <= cfg_pol;
            end
            r_pending <= w_accept | (r_pending & ~w_apply);
            r_err     <= cfg_valid & ~w_cfg_ok;

            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_hblank <= w_hblank_nxt;
            r_vblank <= w_vblank_nxt;
            r_de     <= ~w_hblank_nxt & ~w_vblank_nxt;
        end
    end

    assign pix_en      = w_pix;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign de          = r_de;
    assign cfg_pending = r_pending;
    assign cfg_err     = r_err;
    assign line_start  = w_pix && (r_hpos == '0);
    assign frame_start = w_pix && (r_hpos == '0) && (r_vpos == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
module tb_video_timing_gen;
    localparam int CW = 12;

    typedef struct packed {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        bit hp; bit vp;
    } mode_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_valid_b;
    logic [4*CW-1:0] cfg_h;
    logic [4*CW-1:0] cfg_v;
    logic [1:0]      cfg_pol;

    logic a_pend, a_err, a_pix, a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
    logic [CW-1:0] a_hpos, a_vpos;
    logic b_pend, b_err, b_pix, b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
    logic [CW-1:0] b_hpos, b_vpos;
    logic [7:0] a_flags, b_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_flags = {a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs, a_pix};
    assign b_flags = {b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs, b_pix};

    video_timing_gen #(
        .CW(CW), .PIX_DIV(1),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol),
        .cfg_pending(a_pend), .cfg_err(a_err), .pix_en(a_pix),
        .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hs), .vsync(a_vs),
        .hblank(a_hb), .vblank(a_vb), .de(a_de),
        .line_start(a_ls), .frame_start(a_fs)
    );

    video_timing_gen #(
        .CW(CW), .PIX_DIV(3),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid_b),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol),
        .cfg_pending(b_pend), .cfg_err(b_err), .pix_en(b_pix),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
        .hblank(b_hb), .vblank(b_vb), .de(b_de),
        .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mode_t mk(input int hd, hf, hs, hb, vd, vf, vs, vb,
                                 input bit hp, vp);
        mode_t m;
        m.hd = hd; m.hf = hf; m.hs = hs; m.hb = hb;
        m.vd = vd; m.vf = vf; m.vs = vs; m.vb = vb;
        m.hp = hp; m.vp = vp;
        return m;
    endfunction

    function automatic logic [4*CW-1:0] pack4(input int a, b, c, d);
        return {CW'(a), CW'(b), CW'(c), CW'(d)};
    endfunction

    // Expected {hsync, vsync, hblank, vblank, de, line_start, frame_start, pix_en}
    function automatic logic [7:0] exp_flags(input int h, v, hd, hf, hs,
                                             vd, vf, vs, input bit hp, vp, pen);
        bit hin, vin, hb, vb;
        hin = (h >= hd + hf) && (h <= hd + hf + hs - 1);
        vin = (v >= vd + vf) && (v <= vd + vf + vs - 1);
        hb  = (h >= hd);
        vb  = (v >= vd);
        return {hin ? hp : ~hp, vin ? vp : ~vp, hb, vb, ~hb & ~vb,
                pen && (h == 0), pen && (h == 0) && (v == 0), pen};
    endfunction

    // Walk DUT A (one clock per pixel) through frame offsets k0..k1-1.
    task automatic run_a(input string tag, input mode_t m, input int k0, k1);
        int ht, vt, h, v;
        ht = m.hd + m.hf + m.hs + m.hb;
        vt = m.vd + m.vf + m.vs + m.vb;
        for (int k = k0; k < k1; k++) begin
            h = k % ht;
            v = (k / ht) % vt;
            check({tag, "_pos"}, {8'd0, a_vpos, a_hpos}, 32'(v * 4096 + h));
            check({tag, "_flags"}, {24'd0, a_flags},
                  {24'd0, exp_flags(h, v, m.hd, m.hf, m.hs, m.vd, m.vf, m.vs,
                                    m.hp, m.vp, 1'b1)});
            tick();
        end
    endtask

    task automatic send_raw(input logic [4*CW-1:0] h, v, input logic [1:0] pol);
        cfg_h     = h;
        cfg_v     = v;
        cfg_pol   = pol;
        cfg_valid = 1'b1;
    endtask

    task automatic send(input mode_t m);
        send_raw(pack4(m.hd, m.hf, m.hs, m.hb), pack4(m.vd, m.vf, m.vs, m.vb),
                 {m.vp, m.hp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        mode_t m0, m1, m2, mb, m3, m4, m5;
        int h, v, p, de_cnt, fsa_cnt, fsb_cnt;

        m0 = mk(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
        m1 = mk(4, 1, 1, 1, 4, 1, 2, 1, 1'b0, 1'b0);
        m2 = mk(6, 1, 1, 1, 4, 1, 2, 1, 1'b0, 1'b0);
        mb = mk(4093, 1, 1, 1, 4, 1, 2, 1, 1'b0, 1'b0);
        m3 = mk(5, 2, 2, 2, 3, 1, 1, 1, 1'b1, 1'b0);
        m4 = mk(3, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
        m5 = mk(2, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);

        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_valid_b = 1'b0;
        cfg_h       = '0;
        cfg_v       = '0;
        cfg_pol     = 2'b00;
        repeat (3) tick();

        // Reset state of both instances
        check("rst_a_pos", {8'd0, a_vpos, a_hpos}, 32'd0);
        check("rst_a_dec", 32'({a_hs, a_vs, a_hb, a_vb, a_de}), 32'b11001);
        check("rst_a_cfg", 32'({a_pend, a_err}), 32'd0);
        check("rst_b_pos", {8'd0, b_vpos, b_hpos}, 32'd0);
        check("rst_b_dec", 32'({b_hs, b_vs, b_hb, b_vb, b_de}), 32'b01001);
        check("rst_b_pix", 32'(b_pix), 32'd0);
        reset = 1'b0;

        // Free run: three frames of A, one frame of B (divide by 3)
        de_cnt = 0; fsa_cnt = 0; fsb_cnt = 0;
        for (int c = 0; c < 360; c++) begin
            h = c % 15;
            v = (c / 15) % 8;
            check("a_pos", {8'd0, a_vpos, a_hpos}, 32'(v * 4096 + h));
            check("a_flags", {24'd0, a_flags},
                  {24'd0, exp_flags(h, v, 8, 2, 3, 4, 1, 2, 1'b0, 1'b0, 1'b1)});
            if (a_de) de_cnt++;
            if (a_fs) fsa_cnt++;
            p = c / 3;
            h = p % 15;
            v = (p / 15) % 8;
            check("b_pos", {8'd0, b_vpos, b_hpos}, 32'(v * 4096 + h));
            check("b_flags", {24'd0, b_flags},
                  {24'd0, exp_flags(h, v, 8, 2, 3, 4, 1, 2, 1'b1, 1'b0,
                                    (c % 3) == 2)});
            if (b_fs) fsb_cnt++;
            tick();
        end
        check("a_de_count", 32'(de_cnt), 32'd96);
        check("a_frame_count", 32'(fsa_cnt), 32'd3);
        check("b_frame_count", 32'(fsb_cnt), 32'd1);

        // Deferred load: request mid-frame, old timing runs to the wrap
        run_a("m0", m0, 0, 35);
        send(m1);
        run_a("m0", m0, 35, 36);
        cfg_valid = 1'b0;
        check("defer_pending", 32'(a_pend), 32'd1);
        check("defer_err", 32'(a_err), 32'd0);
        run_a("m0", m0, 36, 120);
        check("apply_pending", 32'(a_pend), 32'd0);
        run_a("m1", m1, 0, 56);

        // Overwrite, rejections, boundary accept
        send(m2);
        run_a("m1", m1, 0, 1);
        check("m2_pending", 32'(a_pend), 32'd1);
        check("m2_err", 32'(a_err), 32'd0);
        send(mb);
        run_a("m1", m1, 1, 2);
        check("sum_4096_err", 32'(a_err), 32'd0);
        send(m3);
        run_a("m1", m1, 2, 3);
        check("m3_err", 32'(a_err), 32'd0);
        send_raw(pack4(5, 2, 0, 2), pack4(3, 1, 1, 1), 2'b01);
        run_a("m1", m1, 3, 4);
        check("zero_h_err", 32'(a_err), 32'd1);
        check("zero_h_pending", 32'(a_pend), 32'd1);
        send_raw(pack4(4094, 1, 1, 1), pack4(3, 1, 1, 1), 2'b01);
        run_a("m1", m1, 4, 5);
        check("sum_4097_h_err", 32'(a_err), 32'd1);
        send_raw(pack4(5, 2, 2, 2), pack4(3, 1, 0, 1), 2'b01);
        run_a("m1", m1, 5, 6);
        check("zero_v_err", 32'(a_err), 32'd1);
        send_raw(pack4(5, 2, 2, 2), pack4(4093, 1, 1, 2), 2'b01);
        run_a("m1", m1, 6, 7);
        check("sum_4097_v_err", 32'(a_err), 32'd1);
        cfg_valid = 1'b0;
        run_a("m1", m1, 7, 8);
        check("err_pulse_end", 32'(a_err), 32'd0);
        run_a("m1", m1, 8, 55);

        // Request on the wrap edge: m3 applies, m4 stays pending
        send(m4);
        run_a("m1", m1, 55, 56);
        cfg_valid = 1'b0;
        check("race_pending", 32'(a_pend), 32'd1);
        check("race_err", 32'(a_err), 32'd0);
        run_a("m3", m3, 0, 66);
        check("race_apply_pending", 32'(a_pend), 32'd0);
        run_a("m4", m4, 0, 30);

        // Reset mid-line with a mode pending
        send(m5);
        run_a("m4", m4, 0, 1);
        cfg_valid = 1'b0;
        check("pre_reset_pending", 32'(a_pend), 32'd1);
        run_a("m4", m4, 1, 17);
        check("pre_reset_pos", {8'd0, a_vpos, a_hpos}, 32'(2 * 4096 + 5));
        reset = 1'b1;
        tick();
        check("mid_rst_pos", {8'd0, a_vpos, a_hpos}, 32'd0);
        check("mid_rst_dec", 32'({a_hs, a_vs, a_hb, a_vb, a_de}), 32'b11001);
        check("mid_rst_cfg", 32'({a_pend, a_err}), 32'd0);
        reset = 1'b0;
        run_a("post_rst", m0, 0, 120);
        check("post_rst_pending", 32'(a_pend), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
